key_evt_fifo: RTL

- Memory-mapped responder on the CPU data bus.
- Synchronises and debounces the 8 board keys, and turns each debounced press or release into an event word.
- Queues events in a FIFO that the CPU drains by polling or on interrupt.
- Sits beside the LED, UART and timer responders. Selected by the address decoder's enable. Read data is OR-combined onto the shared data-in bus, so dout must be zero when not responding.

---
 rtl/key_evt_fifo.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - debounced key event queue, polled or interrupt-driven bus responder
module key_evt_fifo #(
   parameter int DB_CYCLES = 500000,
   parameter int DEPTH     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        evt_en,
   input  logic        re,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] din,
   input  logic [7:0]  key,
   output logic [31:0] dout,
   output logic        ready,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
   localparam logic [CW-1:0] TICK_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] TICK_ONE  = CW'(1);

   typedef enum logic {IDLE, RESP} state_t;

   state_t        state_q, state_d;
   logic          ready_q, ready_d;
   logic [31:0]   dout_q, dout_d;
   logic          irq_q, irq_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          ovf_q, ovf_d;
   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
   logic [7:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [7:0]    sample_q, sample_d, stable_q, stable_d, pending_q, pending_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    mem_q [DEPTH];

   logic          tick;
   logic [7:0]    chg, clr_mask;
   logic [2:0]    push_idx;
   logic          push, pop, push_ok, full, not_empty, req;
   logic [3:0]    head;
   logic [31:0]   rdata;
   logic          unused_ok;

   assign unused_ok = ^{din[31:3], addr[1:0]};

   // Synchronise keys, run the shared sample tick, and move stable state on two agreeing samples
   always_comb begin
      sync1_d    = key;
      sync2_d    = sync1_q;
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
      sample_d   = tick ? sync2_q : sample_q;
      chg        = tick ? (~(sync2_q ^ sample_q) & (sync2_q ^ stable_q)) : 8'h00;
      stable_d   = stable_q ^ chg;
   end

   // Pick the lowest pending key for this cycle's push; disabling flushes pending changes
   always_comb begin
      push_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending_q[i]) push_idx = 3'(i);
      end
      push      = ctrl_q[0] && (|pending_q);
      clr_mask  = 8'h01 << push_idx;
      pending_d = ctrl_q[0] ? ((pending_q & ~clr_mask) | chg) : 8'h00;
   end

   // FIFO bookkeeping, register file and the two-state bus responder
   always_comb begin
      full      = (cnt_q == FULL_CNT);
      not_empty = (cnt_q != '0);
      req       = (state_q == IDLE) && evt_en && (re || we);
      pop       = req && !we && (addr[3:2] == 2'd1) && not_empty;
      push_ok   = push && (!full || pop);
      head      = mem_q[rptr_q[AW-1:0]];

      case (addr[3:2])
         2'd0:    rdata = {20'd0, ovf_q, full, 9'(cnt_q), not_empty};
         2'd1:    rdata = not_empty ? {1'b1, 22'd0, head[3], 5'd0, head[2:0]} : 32'd0;
         2'd2:    rdata = {30'd0, ctrl_q};
         default: rdata = {24'd0, stable_q};
      endcase

      wptr_d = push_ok ? wptr_q + PTR_ONE : wptr_q;
      rptr_d = pop ? rptr_q + PTR_ONE : rptr_q;
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + PTR_ONE;
         2'b01:   cnt_d = cnt_q - PTR_ONE;
         default: cnt_d = cnt_q;
      endcase

      ctrl_d = ctrl_q;
      ovf_d  = ovf_q;
      if (req && we && (addr[3:2] == 2'd2)) begin
         ctrl_d = din[1:0];
         if (din[2]) ovf_d = 1'b0;
      end
      // a dropped event in the same cycle as a clear keeps the flag set
      if (push && full && !pop) ovf_d = 1'b1;

      irq_d = ctrl_q[1] && not_empty;

      state_d = state_q;
      ready_d = 1'b0;
      dout_d  = 32'd0;
      case (state_q)
         IDLE: if (req) begin
            state_d = RESP;
            ready_d = 1'b1;
            dout_d  = we ? 32'd0 : rdata;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register all control state and the bus FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         dout_q     <= 32'd0;
         irq_q      <= 1'b0;
         ctrl_q     <= 2'd0;
         ovf_q      <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         sync1_q    <= 8'h00;
         sync2_q    <= 8'h00;
         sample_q   <= 8'h00;
         stable_q   <= 8'h00;
         pending_q  <= 8'h00;
         tick_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         dout_q     <= dout_d;
         irq_q      <= irq_d;
         ctrl_q     <= ctrl_d;
         ovf_q      <= ovf_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sample_q   <= sample_d;
         stable_q   <= stable_d;
         pending_q  <= pending_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // Event storage holds only {press, key index}; the bus word is rebuilt on read
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= {stable_q[push_idx], push_idx};
   end

   assign ready = ready_q;
   assign dout  = dout_q;
   assign irq   = irq_q;

endmodule
